// File: rtl/clock_gen_multi.sv
// -----------------------------------------------------------------------------
// clock_gen_multi
//
// Multi-channel programmable clock divider. Each of N_CH channels produces a
// divided clock with runtime-programmable period and high time, plus a
// one-cycle tick at the start of every output period. New settings are held
// in a shadow register and only take effect at a period boundary, so an
// output never shows a runt pulse. A global sync restarts all channels in
// phase.
//
// Ports:
//   clk_i         master clock, all logic on posedge
//   rst_ni        asynchronous active-low reset
//   ch_en_i       per-channel enable (level)
//   load_i        one-cycle strobe: write period_in_i/high_in_i to load_ch_i
//   load_ch_i     target channel of a load (values >= N_CH are ignored)
//   period_in_i   requested period in clk cycles (clamped to >= 2)
//   high_in_i     requested high time in clk cycles (clamped to 1..period-1)
//   sync_i        one-cycle strobe: restart all channels in phase
//   clk_out_o     divided clocks (registered)
//   tick_o        one-cycle pulse at the start of each period (registered)
//   pending_o     a shadow write is waiting for the next period boundary
// -----------------------------------------------------------------------------
module clock_gen_multi #(
    parameter int MASTER_CLK_FRQ = 12000000,
    parameter int N_CH           = 4,
    parameter int CNT_W          = 24,
    parameter int DEF_PERIOD_MS  = 1000,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_CH-1:0]  ch_en_i,
    input  logic             load_i,
    input  logic [CH_W-1:0]  load_ch_i,
    input  logic [CNT_W-1:0] period_in_i,
    input  logic [CNT_W-1:0] high_in_i,
    input  logic             sync_i,
    output logic [N_CH-1:0]  clk_out_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  pending_o
);

    localparam logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(MASTER_CLK_FRQ / 1000 * DEF_PERIOD_MS);
    localparam logic [CNT_W-1:0] DEF_HIGH   = DEF_PERIOD >> 1;

    // Clamped load values, shared by all channels. The clamp guarantees the
    // output has both a high and a low phase in every period.
    logic [CNT_W-1:0] load_period;
    logic [CNT_W-1:0] load_high;
    logic [CNT_W-1:0] high_floor;

    always_comb begin
        load_period = (period_in_i < CNT_W'(2)) ? CNT_W'(2) : period_in_i;
        high_floor  = (high_in_i == '0) ? CNT_W'(1) : high_in_i;
        load_high   = (high_floor > load_period - CNT_W'(1)) ? load_period - CNT_W'(1)
                                                             : high_floor;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q,      cnt_d;
        logic [CNT_W-1:0] period_q,   period_d;
        logic [CNT_W-1:0] high_q,     high_d;
        logic [CNT_W-1:0] period_s_q, period_s_d;
        logic [CNT_W-1:0] high_s_q,   high_s_d;
        logic             pending_q,  pending_d;
        logic             clk_out_q,  clk_out_d;
        logic             tick_q,     tick_d;
        logic             sel;
        logic             wrap;

        assign sel  = load_i && (load_ch_i == CH_W'(i));
        assign wrap = (cnt_q == period_q - CNT_W'(1));

        always_comb begin
            cnt_d      = cnt_q;
            period_d   = period_q;
            high_d     = high_q;
            period_s_d = period_s_q;
            high_s_d   = high_s_q;
            pending_d  = pending_q;
            clk_out_d  = clk_out_q;
            tick_d     = tick_q;

            if (sync_i) begin
                // Sync is a period boundary for every channel; a load in the
                // same cycle bypasses the shadow entirely.
                cnt_d     = '0;
                clk_out_d = 1'b0;
                tick_d    = 1'b0;
                pending_d = 1'b0;
                if (sel) begin
                    period_d = load_period;
                    high_d   = load_high;
                end else if (pending_q) begin
                    period_d = period_s_q;
                    high_d   = high_s_q;
                end
            end else if (!ch_en_i[i]) begin
                // A disabled channel sits at its period start, so any
                // outstanding shadow can be applied right away.
                cnt_d     = '0;
                clk_out_d = 1'b0;
                tick_d    = 1'b0;
                pending_d = 1'b0;
                if (pending_q) begin
                    period_d = period_s_q;
                    high_d   = high_s_q;
                end
                if (sel) begin
                    period_d = load_period;
                    high_d   = load_high;
                end
            end else begin
                clk_out_d = (cnt_q < high_q);
                tick_d    = (cnt_q == '0);
                cnt_d     = wrap ? '0 : cnt_q + CNT_W'(1);
                // The old shadow is applied at this wrap before a same-cycle
                // load re-arms pending for the following wrap.
                if (wrap && pending_q) begin
                    period_d  = period_s_q;
                    high_d    = high_s_q;
                    pending_d = 1'b0;
                end
                if (sel) begin
                    period_s_d = load_period;
                    high_s_d   = load_high;
                    pending_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q      <= '0;
                period_q   <= DEF_PERIOD;
                high_q     <= DEF_HIGH;
                period_s_q <= DEF_PERIOD;
                high_s_q   <= DEF_HIGH;
                pending_q  <= 1'b0;
                clk_out_q  <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                cnt_q      <= cnt_d;
                period_q   <= period_d;
                high_q     <= high_d;
                period_s_q <= period_s_d;
                high_s_q   <= high_s_d;
                pending_q  <= pending_d;
                clk_out_q  <= clk_out_d;
                tick_q     <= tick_d;
            end
        end

        assign clk_out_o[i] = clk_out_q;
        assign tick_o[i]    = tick_q;
        assign pending_o[i] = pending_q;
    end

endmodule
